// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared FSM encoding and counter widths for the instruction loader.
// Revision : 1.0
// ============================================================================
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

    // One extra bit so a full memory (2^addr_w words) is representable.
    function automatic int word_cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int gap_cnt_w(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_word_packer
// Brief    : Big-endian byte-to-word assembly and running XOR checksum.
// Revision : 1.0
// ============================================================================
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_hdr_acc,
    input  logic        i_data_acc,
    input  logic [7:0]  i_data,
    output logic        o_word_done,
    output logic [31:0] o_word,
    output logic [7:0]  o_csum
);

    logic [BYTE_IDX_W-1:0] r_idx;
    logic [23:0]           r_shift;
    logic [7:0]            r_csum;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_idx   <= '0;
            r_shift <= '0;
            r_csum  <= '0;
        end else begin
            if (i_hdr_acc || i_data_acc) begin
                r_csum <= r_csum ^ i_data;
            end
            if (i_data_acc) begin
                r_shift <= {r_shift[15:0], i_data};
                r_idx   <= r_idx + BYTE_IDX_W'(1);
            end
        end
    end

    // The fourth byte completes the word in the same cycle it is accepted.
    assign o_word      = {r_shift, i_data};
    assign o_word_done = i_data_acc && (r_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign o_csum      = r_csum;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Loads a checksummed byte stream into instruction memory while
//            holding the CPU in reset; releases the CPU on a good checksum.
// Revision : 1.0
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WCNT_W = word_cnt_w(ADDR_W);
    localparam int GAP_W  = gap_cnt_w(TIMEOUT_CYC);
    localparam logic [WCNT_W-1:0] c_max_words = WCNT_W'(1) << ADDR_W;
    localparam logic [GAP_W-1:0]  c_gap_limit = GAP_W'(TIMEOUT_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_in_ready;
    logic                r_im_we;
    logic [ADDR_W-1:0]   r_im_waddr;
    logic [31:0]         r_im_wdata;
    logic                r_cpu_rst_n;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [ADDR_W-1:0]   r_addr;
    logic [WCNT_W-1:0]   r_words;
    logic [WCNT_W-1:0]   r_nwords;
    logic [GAP_W-1:0]    r_gap;

    logic                w_accept;
    logic                w_hdr_acc;
    logic                w_data_acc;
    logic                w_start_load;
    logic                w_load_ok;
    logic                w_timeout;
    logic                w_last_word;
    logic                w_busy_nxt;
    logic [GAP_W-1:0]    w_gap_nxt;
    logic [WCNT_W-1:0]   w_hdr_n;
    logic                w_word_done;
    logic [31:0]         w_word;
    logic [7:0]          w_csum;

    assign w_accept    = in_valid && r_in_ready;
    assign w_hdr_acc   = w_accept && (r_state == ST_HEADER);
    assign w_data_acc  = w_accept && (r_state == ST_LOAD);
    assign w_gap_nxt   = r_gap + GAP_W'(1);
    // Fires on the idle cycle that would bring the gap count to its limit.
    assign w_timeout   = !w_accept && (w_gap_nxt >= c_gap_limit);
    assign w_last_word = (r_words == r_nwords - WCNT_W'(1));

    // Header 0 or anything beyond the memory size means "fill the memory".
    always_comb begin
        if ((in_data == 8'd0) || ({24'd0, in_data} > 32'(c_max_words))) begin
            w_hdr_n = c_max_words;
        end else begin
            w_hdr_n = WCNT_W'(in_data);
        end
    end

    imem_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_load),
        .i_hdr_acc   (w_hdr_acc),
        .i_data_acc  (w_data_acc),
        .i_data      (in_data),
        .o_word_done (w_word_done),
        .o_word      (w_word),
        .o_csum      (w_csum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_load = 1'b0;
        w_load_ok    = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    w_state_nxt  = ST_HEADER;
                    w_start_load = 1'b1;
                end
            end
            ST_HEADER: begin
                if (w_accept) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_LOAD: begin
                if (w_word_done && w_last_word) begin
                    w_state_nxt = ST_CHECK;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_CHECK: begin
                if (w_accept) begin
                    if (in_data == w_csum) begin
                        w_state_nxt = ST_IDLE;
                        w_load_ok   = 1'b1;
                    end else begin
                        w_state_nxt = ST_ERR;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == ST_HEADER) || (w_state_nxt == ST_LOAD) ||
                        (w_state_nxt == ST_CHECK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_im_we     <= 1'b0;
            r_im_waddr  <= '0;
            r_im_wdata  <= '0;
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_words     <= '0;
            r_nwords    <= '0;
            r_gap       <= '0;
        end else begin
            r_in_ready <= w_busy_nxt;
            r_busy     <= w_busy_nxt;
            r_err      <= (w_state_nxt == ST_ERR);
            r_done     <= w_load_ok;
            r_im_we    <= w_word_done;

            if (w_word_done) begin
                r_im_waddr <= r_addr;
                r_im_wdata <= w_word;
                r_addr     <= r_addr + ADDR_W'(1);
                r_words    <= r_words + WCNT_W'(1);
            end

            if (w_hdr_acc) begin
                r_nwords <= w_hdr_n;
            end

            if (w_start_load) begin
                r_addr   <= '0;
                r_words  <= '0;
                r_nwords <= '0;
            end

            if (w_start_load || w_accept || !r_busy) begin
                r_gap <= '0;
            end else begin
                r_gap <= w_gap_nxt;
            end

            // The CPU stays held from start until a good checksum releases it.
            if (w_load_ok) begin
                r_cpu_rst_n <= 1'b1;
            end else if (w_start_load || (w_state_nxt == ST_ERR)) begin
                r_cpu_rst_n <= 1'b0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign im_we     = r_im_we;
    assign im_waddr  = r_im_waddr;
    assign im_wdata  = r_im_wdata;
    assign cpu_rst_n = r_cpu_rst_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire
